// File: rtl/lsu_mem_port.sv
// Purpose: load/store initiator for port 1 of a byte-enable data RAM; splits word-crossing accesses in two.
// Latency: response two cycles after accept (aligned), three cycles when split; optional LSU_MISALIGN_TRAP_EN traps splits.
// Backpressure: req_ready only in IDLE; rsp_valid is a single-cycle pulse with no backpressure.
module lsu_mem_port #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AWIDTH+1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [3:0]        mem_wbe,
    output logic [DWIDTH-1:0] mem_d,
    output logic              mem_wen,
    input  logic [DWIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, uns_q;
    logic [1:0]          size_q;
    logic [AWIDTH+1:0]   addr_q;
    logic [DWIDTH-1:0]   wdata_q;
    logic [DWIDTH-1:0]   q0_q;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [1:0]          off;
    logic [2:0]          nbytes;
    logic [3:0]          nmask;
    logic                split;
    logic                trap;
    logic [7:0]          lane_mask;
    logic [2*DWIDTH-1:0] wide_d;
    logic [2*DWIDTH-1:0] qpair;
    logic [DWIDTH-1:0]   qsh;
    logic [DWIDTH-1:0]   load_res;
    logic [AWIDTH-1:0]   w0, w1;

    assign off       = addr_q[1:0];
    assign w0        = addr_q[AWIDTH+1:2];
    assign w1        = w0 + AWIDTH'(1);
    assign split     = (({1'b0, off} + nbytes) > 3'd4);
    // Lanes 3:0 belong to the first word, lanes 7:4 spill into the next word.
    assign lane_mask = {4'b0000, nmask} << off;
    assign wide_d    = {{DWIDTH{1'b0}}, wdata_q} << {off, 3'b000};
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = split;
`else
    assign trap = 1'b0;
`endif

    // Access width decode; reserved size behaves as a word.
    always_comb begin
        nbytes = 3'd4;
        nmask  = 4'b1111;
        case (size_q)
            2'b00:   begin nbytes = 3'd1; nmask = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; nmask = 4'b0011; end
            default: begin nbytes = 3'd4; nmask = 4'b1111; end
        endcase
    end

    // Align the load bytes (second word only contributes in ACC1) and extend to full width.
    always_comb begin
        qpair    = (state_q == ACC1) ? {mem_q, q0_q} : {{DWIDTH{1'b0}}, mem_q};
        qsh      = DWIDTH'(qpair >> {off, 3'b000});
        load_res = qsh;
        case (size_q)
            2'b00:   load_res = uns_q ? {{(DWIDTH-8){1'b0}}, qsh[7:0]}
                                      : {{(DWIDTH-8){qsh[7]}}, qsh[7:0]};
            2'b01:   load_res = uns_q ? {{(DWIDTH-16){1'b0}}, qsh[15:0]}
                                      : {{(DWIDTH-16){qsh[15]}}, qsh[15:0]};
            default: load_res = qsh;
        endcase
    end

    // Next state, memory drive and response data; memory outputs depend on registers only.
    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_addr = '0;
        mem_wbe  = 4'b0000;
        mem_d    = '0;
        mem_wen  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = ACC0;
            end
            ACC0: begin
                if (trap) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    mem_addr = w0;
                    mem_wbe  = lane_mask[3:0];
                    mem_d    = wide_d[DWIDTH-1:0];
                    mem_wen  = we_q;
                    state_d  = split ? ACC1 : RESP;
                    rdata_d  = we_q ? '0 : load_res;
                    err_d    = (size_q == 2'b11);
                end
            end
            ACC1: begin
                mem_addr = w1;
                mem_wbe  = lane_mask[7:4];
                mem_d    = wide_d[2*DWIDTH-1:DWIDTH];
                mem_wen  = we_q;
                state_d  = RESP;
                rdata_d  = we_q ? '0 : load_res;
                err_d    = (size_q == 2'b11);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request capture, first-word read capture and response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            q0_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ACC0) q0_q <= mem_q;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Purpose: directed checks of lsu_mem_port against a byte-enable RAM model.
// Latency: expects responses at accept+2 (aligned) or accept+3 (split).
// Backpressure: requests are issued only when req_ready is seen high.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [11:0] mem_addr;
    logic [3:0]  mem_wbe;
    logic [31:0] mem_d, mem_q;
    logic        mem_wen;

    logic [31:0] mem [0:4095];
    logic        mem_clr;

    int n_cmp = 0;
    int n_mis = 0;

    logic [11:0] a0_addr, a1_addr;
    logic [3:0]  a0_wbe, a1_wbe;
    logic [31:0] a0_d, a1_d;
    logic        a0_wen, a1_wen;
    int          lat;
    logic [31:0] r_data;
    logic        r_err;

    always #5 clk = ~clk;

    lsu_mem_port #(.AWIDTH(12), .DWIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wbe(mem_wbe),
        .mem_d(mem_d), .mem_wen(mem_wen), .mem_q(mem_q)
    );

    // RAM model: asynchronous read, synchronous byte-enabled write.
    assign mem_q = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
        end else if (mem_wen) begin
            for (int i = 0; i < 4; i++)
                if (mem_wbe[i]) mem[mem_addr][8*i +: 8] <= mem_d[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and record the memory drive in the first two cycles plus the response.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [13:0] a, input logic [31:0] wd);
        int k;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 5 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin a0_addr = mem_addr; a0_wbe = mem_wbe; a0_d = mem_d; a0_wen = mem_wen; end
            if (c == 2) begin a1_addr = mem_addr; a1_wbe = mem_wbe; a1_d = mem_d; a1_wen = mem_wen; end
            if (rsp_valid) begin lat = c; r_data = rsp_rdata; r_err = rsp_err; end
        end
        @(negedge clk);
        check("rsp_pulse_one_cycle", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; mem_clr = 1'b1;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'b0, rsp_err}, 32'd0);
        check("rst_mem_addr", {20'b0, mem_addr}, 32'h0);
        check("rst_mem_wbe", {28'b0, mem_wbe}, 32'h0);
        check("rst_mem_d", mem_d, 32'h0);
        check("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
        rstn = 1'b1;

        // SW 0x0A0
        xact(1'b1, 2'b10, 1'b0, 14'h0A0, 32'hDEADBEEF);
        check("sw_a0_addr", {20'b0, a0_addr}, 32'h028);
        check("sw_a0_wbe", {28'b0, a0_wbe}, 32'hF);
        check("sw_a0_d", a0_d, 32'hDEADBEEF);
        check("sw_a0_wen", {31'b0, a0_wen}, 32'd1);
        check("sw_lat", lat, 32'd2);
        check("sw_err", {31'b0, r_err}, 32'd0);
        check("sw_rdata", r_data, 32'h0);

        // SB 0x0A1
        xact(1'b1, 2'b00, 1'b0, 14'h0A1, 32'h000000AB);
        check("sb_wbe", {28'b0, a0_wbe}, 32'h2);
        check("sb_d", a0_d, 32'h0000AB00);
        check("sb_lat", lat, 32'd2);

        // Loads on the merged word
        xact(1'b0, 2'b10, 1'b0, 14'h0A0, 32'h0);
        check("lw_rdata", r_data, 32'hDEADABEF);
        check("lw_wen", {31'b0, a0_wen}, 32'd0);
        check("lw_lat", lat, 32'd2);
        xact(1'b0, 2'b00, 1'b0, 14'h0A3, 32'h0);
        check("lb_rdata", r_data, 32'hFFFFFFDE);
        xact(1'b0, 2'b00, 1'b1, 14'h0A3, 32'h0);
        check("lbu_rdata", r_data, 32'h000000DE);
        xact(1'b0, 2'b01, 1'b0, 14'h0A2, 32'h0);
        check("lh_rdata", r_data, 32'hFFFFDEAD);
        xact(1'b0, 2'b01, 1'b1, 14'h0A0, 32'h0);
        check("lhu_rdata", r_data, 32'h0000ABEF);

        // Reserved size: word access with error flag
        xact(1'b0, 2'b11, 1'b0, 14'h0A0, 32'h0);
        check("rsv_rdata", r_data, 32'hDEADABEF);
        check("rsv_err", {31'b0, r_err}, 32'd1);
        xact(1'b0, 2'b10, 1'b0, 14'h0A0, 32'h0);
        check("err_clears", {31'b0, r_err}, 32'd0);

        // Split SW 0x0A6
        xact(1'b1, 2'b10, 1'b0, 14'h0A6, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
        check("trap_sw_wen", {31'b0, a0_wen}, 32'd0);
        check("trap_sw_wbe", {28'b0, a0_wbe}, 32'h0);
        check("trap_sw_lat", lat, 32'd2);
        check("trap_sw_err", {31'b0, r_err}, 32'd1);
        check("trap_sw_nowrite", mem[12'h029], 32'h0);
        xact(1'b0, 2'b10, 1'b0, 14'h0A6, 32'h0);
        check("trap_lw_rdata", r_data, 32'h0);
        check("trap_lw_err", {31'b0, r_err}, 32'd1);
`else
        check("ssw_a0_addr", {20'b0, a0_addr}, 32'h029);
        check("ssw_a0_wbe", {28'b0, a0_wbe}, 32'hC);
        check("ssw_a0_d", a0_d, 32'h33440000);
        check("ssw_a1_addr", {20'b0, a1_addr}, 32'h02A);
        check("ssw_a1_wbe", {28'b0, a1_wbe}, 32'h3);
        check("ssw_a1_d", a1_d, 32'h00001122);
        check("ssw_a1_wen", {31'b0, a1_wen}, 32'd1);
        check("ssw_lat", lat, 32'd3);
        check("ssw_err", {31'b0, r_err}, 32'd0);
        xact(1'b0, 2'b10, 1'b0, 14'h0A6, 32'h0);
        check("slw_rdata", r_data, 32'h11223344);
        check("slw_lat", lat, 32'd3);
`endif

        // SH 0x3FFF: split across the top of the address space, wraps to word 0
        xact(1'b1, 2'b01, 1'b0, 14'h3FFF, 32'h0000BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
        check("trap_sh_err", {31'b0, r_err}, 32'd1);
        check("trap_sh_lat", lat, 32'd2);
`else
        check("wrap_a0_addr", {20'b0, a0_addr}, 32'hFFF);
        check("wrap_a0_wbe", {28'b0, a0_wbe}, 32'h8);
        check("wrap_a0_d", a0_d, 32'hEF000000);
        check("wrap_a1_addr", {20'b0, a1_addr}, 32'h000);
        check("wrap_a1_wbe", {28'b0, a1_wbe}, 32'h1);
        check("wrap_a1_d", a1_d, 32'h000000BE);
        xact(1'b0, 2'b01, 1'b1, 14'h3FFF, 32'h0);
        check("wrap_lhu_rdata", r_data, 32'h0000BEEF);
`endif

`ifndef LSU_MISALIGN_TRAP_EN
        // Reset during ACC1 of a split store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 14'h0A6; req_wdata = 32'h55667788;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_acc0_wen", {31'b0, mem_wen}, 32'd1);
        @(posedge clk);
        #2;
        check("rst_mid_acc1_addr", {20'b0, mem_addr}, 32'h02A);
        rstn = 1'b0;
        #1;
        check("rst_mid_wen", {31'b0, mem_wen}, 32'd0);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_rsp", {31'b0, rsp_valid}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        rstn = 1'b1;
        check("rst_mid_word29", mem[12'h029], 32'h77880000);
        check("rst_mid_word2a", mem[12'h02A], 32'h00001122);
        xact(1'b0, 2'b10, 1'b0, 14'h0A6, 32'h0);
        check("rst_mid_lw", r_data, 32'h11227788);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator for the data port (port 1) of the dual-port, async-read / sync-write, byte-enable data memory (ASYNC_RAM_DP_WBE).
- Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests from the core.
- Drives word address, byte enables, lane-shifted write data and write enable to the memory.
- Returns aligned, sign- or zero-extended load data. Accesses that cross a word boundary are split into two consecutive memory cycles.

Parameters:
- AWIDTH, 12, memory word-address width; byte address is AWIDTH+2 bits.
- DWIDTH, 32, memory data width; 32 is the only supported value.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; the request is accepted on a clock edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  load zero-extends when 1.
- req_addr  in  AWIDTH+2  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  32  load result; 0 for stores.
- rsp_err  out  1  reserved size, or trap (see Optional Feature).
- mem_addr  out  AWIDTH  word address; connects to addr1.
- mem_wbe  out  4  byte enables; connects to wbe1.
- mem_d  out  32  write data; connects to d1.
- mem_wen  out  1  write enable; connects to wen1.
- mem_q  in  32  combinational read data; connects to q1.

Behaviour:
- Reset (async, rstn=0): state IDLE.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 1.
  - mem_addr = 0, mem_wbe = 0, mem_d = 0, mem_wen = 0.
- Memory outputs are decoded from the state and request registers only. They are all zero outside ACC0/ACC1, so reset deasserts mem_wen immediately.
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE -> ACC0 on accept; the request is registered.
  - ACC0 -> ACC1 if the access spans two words, else -> RESP.
  - ACC1 -> RESP.
  - RESP -> IDLE; rsp_valid = 1 for exactly this cycle.
- Latency from the accept edge T: aligned access responds in the cycle after T+1 (rsp_valid during T+2); split access responds at T+3.
- Sizing and lanes:
  - Byte offset o = addr[1:0]; n = 1, 2 or 4 bytes (size 11 is treated as word with rsp_err = 1).
  - Little-endian: byte lane i = bits 8i+7:8i, enabled by wbe[i].
  - Split condition: o + n > 4.
  - W0 = addr[AWIDTH+1:2]; W1 = W0 + 1 mod 2^AWIDTH, so it wraps to 0.
- ACC0:
  - mem_addr = W0.
  - mem_wbe = lanes o .. min(3, o+n-1).
  - mem_d = wdata << 8o.
  - mem_wen = req_we.
- ACC1:
  - mem_addr = W1.
  - mem_wbe = lanes 0 .. o+n-5.
  - mem_d = wdata >> 8(4-o).
  - mem_wen = req_we.
- Loads: mem_wbe is still driven but mem_wen = 0. mem_q is captured at the end of ACC0 into q0 and at the end of ACC1 into q1 (q1 = 0 when not split).
  - Result = ({q1,q0} >> 8o), truncated to n bytes.
  - Sign-extended when req_unsigned = 0, zero-extended when 1; registered into rsp_rdata at entry to RESP.
- Stores: rsp_rdata = 0.
- rsp_rdata and rsp_err hold their values until the next response.
- Reset mid-operation:
  - Aborts the operation; no response is issued.
  - A split store interrupted during ACC1 leaves only the ACC0 half written; this is accepted behaviour.
- req_valid while busy: ignored; the requester holds it until it sees req_ready.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Any split request goes ACC0 -> RESP with mem_wen = 0 and mem_wbe = 0 in ACC0.
  - Response is rsp_err = 1, rsp_rdata = 0; latency is as for an aligned access.
- Undefined: split behaviour as specified above; misaligned accesses never set rsp_err.

Test Plan:
- SW 0x0A0, wdata 0xDEADBEEF -> at T+1: mem_addr = 0x028, wbe = 1111, d = 0xDEADBEEF, wen = 1; rsp_valid at T+2, rsp_err = 0.
- SB 0x0A1, wdata 0x000000AB -> wbe = 0010, d = 0x0000AB00; then LW 0x0A0 -> rsp_rdata = 0xDEADABEF.
- LB 0x0A3 -> 0xFFFFFFDE; LBU 0x0A3 -> 0x000000DE; LH 0x0A2 -> 0xFFFFDEAD; LHU 0x0A0 -> 0x0000ABEF.
- SW 0x0A6, wdata 0x11223344:
  - ACC0: addr 0x029, wbe 1100, d 0x33440000.
  - ACC1: addr 0x02A, wbe 0011, d 0x00001122.
  - rsp at T+3; then LW 0x0A6 -> 0x11223344.
  - With LSU_MISALIGN_TRAP_EN: no write, rsp_err = 1 at T+2.
- SH 0x3FFF, wdata 0xBEEF:
  - ACC0: addr 0xFFF, wbe 1000, d 0xEF000000.
  - ACC1: addr 0x000, wbe 0001, d 0x000000BE.
  - LHU 0x3FFF -> 0x0000BEEF.
- Assert rstn = 0 during ACC1 of a split store -> mem_wen = 0 in the same cycle, req_ready = 1, no rsp_valid; word 0x029 holds the new upper half, word 0x02A is unchanged.
